buffer_reader: RTL

- Scan-out engine for the double-buffered sample RAM (`buffer`). This is the read end of the writer/reader pair.
- Sequentially fetches all RAM_DEPTH words of the front bank at a paced rate and presents each word on a valid/ready sample stream toward the DAC/LED driver.
- At each frame boundary, issues the one-cycle `swap_en` to the buffer if the writer has flagged a completed back bank; otherwise replays the current front bank.

---
 rtl/buffer_pkg.sv | 23 ++
 rtl/sample_pacer.sv | 34 +++
 rtl/buffer_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// ============================================================================
// buffer_pkg: shared widths and reader state encoding for the sample buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package buffer_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SWAP      = 3'd1,
        WAIT_TICK = 3'd2,
        FETCH     = 3'd3,
        LATCH     = 3'd4,
        HOLD      = 3'd5
    } reader_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_pacer.sv
// ============================================================================
// sample_pacer: free-running 0..SAMPLE_DIV-1 counter, tick on the last count
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_pacer #(
    parameter int SAMPLE_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLE_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/buffer_reader.sv
// ============================================================================
// buffer_reader: paced scan-out of the front bank with frame-boundary swap
// Rev 1.0
// ============================================================================
`default_nettype none

module buffer_reader #(
    parameter int DATA_W     = buffer_pkg::DATA_W,
    parameter int ADDR_W     = buffer_pkg::ADDR_W,
    parameter int RAM_DEPTH  = 1024,
    parameter int SAMPLE_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_ready,
    output logic              en,
    output logic              swap_en,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              frame_done,
    output logic              overrun
);

    import buffer_pkg::*;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(RAM_DEPTH - 1);

    reader_state_t     r_state;
    reader_state_t     w_state_nxt;
    logic              r_pending;
    logic              r_overrun;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sample;
    logic              w_tick;
    logic              w_accept;
    logic              w_last;

    sample_pacer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_pacer (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_accept = (r_state == HOLD) && r_valid && sample_ready;
    assign w_last   = (r_addr == c_last_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        en          = 1'b0;
        swap_en     = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_nxt = SWAP;
                end
            end
            SWAP: begin
                en          = 1'b1;
                swap_en     = 1'b1;
                w_state_nxt = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (w_tick) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                en          = 1'b1;
                w_state_nxt = LATCH;
            end
            LATCH: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_accept) begin
                    frame_done  = w_last;
                    // Without a pending bank the same front bank is replayed.
                    w_state_nxt = (w_last && r_pending) ? SWAP : WAIT_TICK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                SWAP: begin
                    r_addr <= '0;
                end
                LATCH: begin
                    r_sample <= rd_data;
                    r_valid  <= 1'b1;
                end
                HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_addr  <= w_last ? '0 : r_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A frame_ready landing on the swap cycle re-arms pending for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (frame_ready) begin
                r_pending <= 1'b1;
            end else if (swap_en) begin
                r_pending <= 1'b0;
            end
            if (frame_ready && r_pending && !swap_en) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign addr         = r_addr;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
